// File: rtl/debug_probe_serializer.sv
// Serialises NUM_CH asynchronous probe bits onto debug_out: round-robin scan,
// framed snapshot (sync word + data + even parity), or single-channel hold.
module debug_probe_serializer #(
   parameter int                NUM_CH    = 16,
   parameter int                ADDR_W    = 4,
   parameter int                SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
   parameter int                CNT_W     = 8
) (
   input  logic              debug_clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] probe_in,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] sel_addr,
   input  logic              sticky_en,
   input  logic              trig_en,
   input  logic [ADDR_W-1:0] trig_sel,
   output logic              debug_out,
   output logic              frame_start,
   output logic [CNT_W-1:0]  frame_count
);

   localparam int BC_MAX = (NUM_CH > SYNC_W) ? NUM_CH : SYNC_W;
   localparam int BC_W   = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;

   typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

   state_t              state, state_n;
   logic [BC_W-1:0]     cnt, cnt_n;
   logic [ADDR_W-1:0]   addr, addr_n;
   logic [1:0]          mode_q;
   logic [NUM_CH-1:0]   sync1, sp, sp_d, acc, snap, snap_src;
   logic [SYNC_W-1:0]   sync_sh;
   logic                par;
   logic                dout_n, fs_n, fc_inc, load, boundary, trig_edge;

   // Channel mux; addresses at or beyond NUM_CH read as 0.
   function automatic logic pick(input logic [NUM_CH-1:0] v, input logic [ADDR_W-1:0] a);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (a == ADDR_W'(i)) r = v[i];
      return r;
   endfunction

   assign boundary  = (state == IDLE) || (state == PAR);
   assign trig_edge = pick(sp, trig_sel) & ~pick(sp_d, trig_sel);
   assign snap_src  = sticky_en ? (acc | sp) : sp;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = '0;
      dout_n  = 1'b0;
      fs_n    = 1'b0;
      fc_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (mode_q == 2'b01) begin
               if (!trig_en || trig_edge) begin
                  state_n = SYNC;
                  cnt_n   = '0;
               end
            end else if (mode_q == 2'b10) begin
               dout_n = pick(sp, sel_addr);
            end else begin
               dout_n = pick(sp, addr);
               fs_n   = (addr == '0);
               addr_n = (addr == ADDR_W'(NUM_CH-1)) ? '0 : addr + 1'b1;
            end
         end
         SYNC: begin
            dout_n = sync_sh[SYNC_W-1];
            fs_n   = (cnt == '0);
            if (cnt == BC_W'(SYNC_W-1)) begin
               state_n = DATA;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            dout_n = snap[0];
            if (cnt == BC_W'(NUM_CH-1)) begin
               state_n = PAR;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PAR: begin
            dout_n  = par;
            fc_inc  = 1'b1;
            cnt_n   = '0;
            // the incoming mode is what the boundary latches, so decide on it
            state_n = (mode == 2'b01 && !trig_en) ? SYNC : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign load = (state_n == SYNC) && (state != SYNC);

   always_ff @(posedge debug_clk or posedge reset) begin
      if (reset) begin
         sync1       <= '0;
         sp          <= '0;
         sp_d        <= '0;
         acc         <= '0;
         snap        <= '0;
         par         <= 1'b0;
         sync_sh     <= '0;
         state       <= IDLE;
         cnt         <= '0;
         addr        <= '0;
         mode_q      <= 2'b00;
         debug_out   <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         sync1       <= probe_in;
         sp          <= sync1;
         sp_d        <= sp;
         state       <= state_n;
         cnt         <= cnt_n;
         addr        <= addr_n;
         debug_out   <= dout_n;
         frame_start <= fs_n;
         if (boundary) mode_q <= mode;
         if (fc_inc) frame_count <= frame_count + 1'b1;
         // snapshot and sync word are shifted out, parity is fixed at capture
         if (load) begin
            snap    <= snap_src;
            par     <= ^snap_src;
            sync_sh <= SYNC_WORD;
            acc     <= '0;
         end else begin
            acc <= acc | sp;
            if (state == SYNC) sync_sh <= sync_sh << 1;
            if (state == DATA) snap <= snap >> 1;
         end
      end
   end

endmodule

// File: tb/tb_debug_probe_serializer.sv
// Scoreboard bench: stimulus queues expected serial frames, a monitor collects
// debug_out from each frame_start and compares.
module tb_debug_probe_serializer;

   logic        debug_clk = 1'b0;
   logic        reset     = 1'b1;
   logic [15:0] probe_in  = 16'h8001;
   logic [1:0]  mode      = 2'b00;
   logic [3:0]  sel_addr  = 4'd4;
   logic        sticky_en = 1'b0;
   logic        trig_en   = 1'b0;
   logic [3:0]  trig_sel  = 4'd3;
   logic        debug_out, frame_start;
   logic [7:0]  frame_count;

   logic [11:0] probe12 = 12'h801;
   logic        d12_out, d12_fs;
   logic [7:0]  d12_fc;

   int n_chk  = 0;
   int n_fail = 0;
   bit strict   = 1'b0;
   bit mon_busy = 1'b0;

   typedef struct {
      logic [63:0] bits;
      int          len;
      int          fc;
      string       name;
   } exp_t;
   exp_t q[$];

   debug_probe_serializer dut (
      .debug_clk(debug_clk), .reset(reset), .probe_in(probe_in), .mode(mode),
      .sel_addr(sel_addr), .sticky_en(sticky_en), .trig_en(trig_en), .trig_sel(trig_sel),
      .debug_out(debug_out), .frame_start(frame_start), .frame_count(frame_count)
   );

   debug_probe_serializer #(.NUM_CH(12)) dut12 (
      .debug_clk(debug_clk), .reset(reset), .probe_in(probe12), .mode(2'b00),
      .sel_addr(4'd0), .sticky_en(1'b0), .trig_en(1'b0), .trig_sel(4'd0),
      .debug_out(d12_out), .frame_start(d12_fs), .frame_count(d12_fc)
   );

   always #5 debug_clk = ~debug_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] bits, input int len, input int fc, input string name);
      exp_t e;
      e.bits = bits; e.len = len; e.fc = fc; e.name = name;
      q.push_back(e);
   endtask

   task automatic wait_q(input int n, input string name);
      int t = 0;
      while (q.size() > n && t < 500) begin
         @(negedge debug_clk);
         t++;
      end
      check(name, 64'(q.size()), 64'(n));
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((q.size() > 0 || mon_busy) && t < 1000) begin
         @(negedge debug_clk);
         t++;
      end
      check(name, 64'(q.size()) + 64'(mon_busy), 64'd0);
   endtask

   // Monitor: first transmitted bit lands at bits[len-1].
   initial begin
      exp_t e;
      logic [63:0] got;
      forever begin
         @(negedge debug_clk);
         if (!reset && frame_start) begin
            if (q.size() > 0) begin
               e = q.pop_front();
               mon_busy = 1'b1;
               got = '0;
               got[e.len-1] = debug_out;
               for (int i = e.len - 2; i >= 0; i--) begin
                  @(negedge debug_clk);
                  got[i] = debug_out;
               end
               check(e.name, got, e.bits);
               if (e.fc >= 0) check({e.name, "_count"}, 64'(frame_count), 64'(e.fc));
               mon_busy = 1'b0;
            end else if (strict) begin
               check("unexpected_frame_start", 64'(frame_start), 64'd0);
            end
         end
      end
   end

   // 12-channel instance: scan period 12, ch0 at frame_start, ch11 just before.
   initial begin
      int  t;
      logic prev;
      wait (reset == 1'b0);
      repeat (5) @(negedge debug_clk);
      t = 0;
      while (!d12_fs && t < 40) begin
         @(negedge debug_clk);
         t++;
      end
      check("scan12_first_fs", 64'(d12_fs), 64'd1);
      for (int k = 0; k < 2; k++) begin
         t = 0;
         prev = 1'b0;
         do begin
            prev = d12_out;
            @(negedge debug_clk);
            t++;
         end while (!d12_fs && t < 40);
         check("scan12_period", 64'(t), 64'd12);
         check("scan12_ch0", 64'(d12_out), 64'd1);
         check("scan12_ch11", 64'(prev), 64'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(negedge debug_clk);
      check("reset_out", 64'(debug_out), 64'd0);
      check("reset_fs", 64'(frame_start), 64'd0);
      check("reset_count", 64'(frame_count), 64'd0);
      reset = 1'b0;

      // scan
      repeat (6) @(negedge debug_clk);
      push(64'(16'b1000_0000_0000_0001), 16, -1, "scan_8001_a");
      push(64'(16'b1000_0000_0000_0001), 16, -1, "scan_8001_b");
      wait_drain("scan_8001_done");
      probe_in = 16'h0006;
      repeat (4) @(negedge debug_clk);
      push(64'(16'b0110_0000_0000_0000), 16, -1, "scan_0006");
      wait_drain("scan_0006_done");

      // framed, free running; third frame is interrupted by a switch to hold
      probe_in = 16'h00F3;
      repeat (4) @(negedge debug_clk);
      mode = 2'b01;
      repeat (2) @(posedge debug_clk);
      #1;
      push(64'(25'b10100101_11001111_00000000_0), 25, 1, "frame_f3_1");
      push(64'(25'b10100101_11001111_00000000_0), 25, 2, "frame_f3_2");
      push(64'(25'b10100101_11001111_00000000_0), 25, 3, "frame_f3_3");
      wait_q(0, "frame_f3_started");
      repeat (15) @(negedge debug_clk);
      mode = 2'b10;
      wait_drain("frame_f3_done");

      // hold
      repeat (2) @(negedge debug_clk);
      check("hold_ch4", 64'(debug_out), 64'd1);
      check("hold_fs", 64'(frame_start), 64'd0);
      sel_addr = 4'd2;
      repeat (2) @(negedge debug_clk);
      check("hold_ch2_low", 64'(debug_out), 64'd0);
      probe_in = 16'h00F7;
      repeat (4) @(negedge debug_clk);
      check("hold_ch2_high", 64'(debug_out), 64'd1);
      check("hold_count_kept", 64'(frame_count), 64'd3);

      // sticky: accumulator still holds the hold-phase value F7 for frame A
      probe_in  = 16'h0000;
      sticky_en = 1'b1;
      repeat (4) @(negedge debug_clk);
      mode = 2'b01;
      repeat (2) @(posedge debug_clk);
      #1;
      push(64'(25'b10100101_11101111_00000000_1), 25, 4, "sticky_a");
      push(64'(25'b10100101_00000100_00000000_1), 25, 5, "sticky_b");
      push(64'(25'b10100101_00000000_00000000_0), 25, 6, "sticky_c");
      wait_q(2, "sticky_a_started");
      repeat (5) @(negedge debug_clk);
      probe_in = 16'h0020;
      @(negedge debug_clk);
      probe_in = 16'h0000;
      wait_q(0, "sticky_c_started");
      trig_en   = 1'b1;
      sticky_en = 1'b0;
      wait_drain("sticky_done");

      // triggered one-shot
      strict = 1'b1;
      repeat (3) @(negedge debug_clk);
      check("idle_out", 64'(debug_out), 64'd0);
      check("idle_fs", 64'(frame_start), 64'd0);
      push(64'(25'b10100101_00010000_00000000_1), 25, 7, "trig_frame");
      probe_in = 16'h0008;
      wait_q(0, "trig_started");
      repeat (5) @(negedge debug_clk);
      probe_in = 16'h0000;
      repeat (3) @(negedge debug_clk);
      probe_in = 16'h0008;
      wait_drain("trig_done");
      repeat (60) @(negedge debug_clk);
      check("trig_single_count", 64'(frame_count), 64'd7);
      check("trig_idle_out", 64'(debug_out), 64'd0);
      strict = 1'b0;

      // async reset during the first sync bit
      trig_en = 1'b0;
      t = 0;
      while (!frame_start && t < 40) begin
         @(negedge debug_clk);
         t++;
      end
      check("pre_reset_out", 64'(debug_out), 64'd1);
      #1 reset = 1'b1;
      #1;
      check("async_reset_out", 64'(debug_out), 64'd0);
      check("async_reset_fs", 64'(frame_start), 64'd0);
      check("async_reset_count", 64'(frame_count), 64'd0);
      repeat (2) @(negedge debug_clk);
      check("queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
